// File: rtl/alu_register.sv
// alu_register: an 8-function ALU whose result is captured in a single
// output register, so a result appears one clock after its operands.
// Optional build macro ALU_REGISTER_SIGNED_LT_EN makes opcode 111 compare
// the operands as two's-complement signed values; by default it compares
// them as unsigned.
module alu_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] second_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LSL  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_LT   = 3'b111;

  logic [WIDTH-1:0]        nand_res;
  logic signed [WIDTH-1:0] first_signed;
  logic [WIDTH-1:0]        asr_res;
  logic [WIDTH-1:0]        lsl_res;
  logic                    lt_bit;
  logic [WIDTH-1:0]        result_next;
  logic [WIDTH-1:0]        result_reg;

  // Per-bit NAND of the two operands.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_nand
      assign nand_res[gi] = ~(first_i[gi] & second_i[gi]);
    end
  endgenerate

  // Shifts use the full unsigned value of B; amounts of WIDTH or more
  // saturate naturally (sign fill for ASR, zero for LSL).
  assign first_signed = $signed(first_i);
  assign asr_res      = first_signed >>> second_i;
  assign lsl_res      = first_i << second_i;

`ifdef ALU_REGISTER_SIGNED_LT_EN
  assign lt_bit = ($signed(first_i) < $signed(second_i));
`else
  assign lt_bit = (first_i < second_i);
`endif

  // Select the function result for the current opcode.
  always_comb begin
    result_next = '0;
    unique case (opcode_i)
      OP_NAND: result_next = nand_res;
      OP_XOR:  result_next = first_i ^ second_i;
      OP_ADD:  result_next = first_i + second_i;
      OP_ASR:  result_next = asr_res;
      OP_OR:   result_next = first_i | second_i;
      OP_LSL:  result_next = lsl_res;
      OP_NOT:  result_next = ~first_i;
      OP_LT:   result_next = {{(WIDTH-1){1'b0}}, lt_bit};
      default: result_next = '0;
    endcase
  end

  // Output register; reset wins over any opcode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign result_o = result_reg;

endmodule

// File: tb/tb_alu_register.sv
// tb_alu_register: directed and randomized checks of alu_register against
// an arithmetic reference model (WIDTH = 8).
module tb_alu_register;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] first_i = '0;
  logic [W-1:0] second_i = '0;
  logic [2:0]   opcode_i = '0;
  logic [W-1:0] result_o;

  int vectors = 0;
  int miscompares = 0;

  alu_register #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .first_i  (first_i),
    .second_i (second_i),
    .opcode_i (opcode_i),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference: operands treated as plain integers in [0, MOD).
  function automatic logic [W-1:0] model(input int op, input int a, input int b);
    int r;
    int sa;
    int sb;
    int p;
    r = 0;
    case (op)
      0: r = (MOD - 1) - (a & b);
      1: r = a ^ b;
      2: r = (a + b) % MOD;
      3: begin
        sa = (a >= MOD / 2) ? a - MOD : a;
        if (b >= W) begin
          r = (sa < 0) ? -1 : 0;
        end else begin
          p = 1 << b;
          // floor division of a signed value by 2^b
          r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        end
        r = (r + MOD) % MOD;
      end
      4: r = a | b;
      5: r = (b >= W) ? 0 : (a * (1 << b)) % MOD;
      6: r = (MOD - 1) - a;
      default: begin
`ifdef ALU_REGISTER_SIGNED_LT_EN
        sa = (a >= MOD / 2) ? a - MOD : a;
        sb = (b >= MOD / 2) ? b - MOD : b;
        r  = (sa < sb) ? 1 : 0;
`else
        sb = 0;
        r  = (a < b) ? 1 : 0;
`endif
      end
    endcase
    return r[W-1:0];
  endfunction

  // Drive one operation, clock it in, and compare the registered result.
  task automatic run_op(input string tag, input int op, input int a, input int b);
    logic [W-1:0] exp;
    opcode_i = op[2:0];
    first_i  = a[W-1:0];
    second_i = b[W-1:0];
    exp = model(op, a, b);
    @(posedge clk_i);
    #1;
    $display("%s op=%0d a=%02h b=%02h result=%02h expect=%02h", tag, op, a, b, result_o, exp);
    check(tag, result_o, exp);
  endtask

  initial begin
    int op;
    int a;
    int b;

    // Reset held for two edges.
    rst_i = 1'b1;
    opcode_i = 3'b010;
    first_i  = 8'h12;
    second_i = 8'h34;
    repeat (2) @(posedge clk_i);
    #1;
    $display("reset result=%02h", result_o);
    check("reset", result_o, 8'h00);
    rst_i = 1'b0;

    // Directed vectors.
    run_op("nand", 0, 'hAA, 'hCC);
    check("nand_const", result_o, 8'h77);
    run_op("xor", 1, 'hF0, 'hAA);
    run_op("or", 4, 'h33, 'h55);
    run_op("not", 6, 'h55, 'h12);
    run_op("add", 2, 100, 50);
    run_op("add_wrap", 2, 'hFF, 'h01);
    run_op("asr2", 3, 'h99, 2);
    check("asr2_const", result_o, 8'hE6);
    run_op("asr7", 3, 'h80, 7);
    run_op("asr9neg", 3, 'h80, 9);
    run_op("asr9pos", 3, 'h40, 9);
    run_op("asr0", 3, 'hC3, 0);
    run_op("lsl2", 5, 'h0F, 2);
    run_op("lsl8", 5, 'h0F, 8);
    run_op("lsl0", 5, 'hA5, 0);
    run_op("lsl255", 5, 'hFF, 255);
    run_op("lt_true", 7, 50, 100);
    run_op("lt_false", 7, 100, 50);
    run_op("lt_equal", 7, 77, 77);
    run_op("lt_80_01", 7, 'h80, 'h01);
`ifdef ALU_REGISTER_SIGNED_LT_EN
    check("lt_80_01_const", result_o, 8'h01);
`else
    check("lt_80_01_const", result_o, 8'h00);
`endif

    // Reset in the middle of a stream of ADDs.
    run_op("add_pre", 2, 'h21, 'h13);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    $display("midreset result=%02h", result_o);
    check("midreset", result_o, 8'h00);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    $display("postreset result=%02h", result_o);
    check("postreset", result_o, 8'h34);

    // Randomized back-to-back operations.
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 1) == 0) b = int'($urandom_range(0, W + 2));
      else b = int'($urandom_range(0, MOD - 1));
      run_op("rand", op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
